// File: rtl/video_timing_out.sv
// rtl/video_timing_out.sv - video timing master and 4:4:4 to 4:2:2 output formatter
// Counters drive the pipeline; returning YCbCr is delay-aligned and chroma-averaged per pixel pair.
module video_timing_out #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int LAT      = 1,
  parameter int SYNC_POL = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic [11:0] pixel,
  output logic [11:0] line,
  output logic        line_end,
  output logic        frame_end,
  output logic        halt,
  input  logic [7:0]  Y,
  input  logic [7:0]  Cb,
  input  logic [7:0]  Cr,
  output logic [15:0] vid_data,
  output logic        vid_de,
  output logic        vid_hs,
  output logic        vid_vs
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] HS_FIRST = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_LAST  = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] VS_FIRST = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_LAST  = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic        SYNC_ON  = (SYNC_POL != 0);

  // Flag bundle order: {de, hs_active, vs_active, pixel[0]}
  logic [3:0] raw_flags;
  logic [3:0] dly [LAT];
  logic [3:0] aligned;
  logic [3:0] prev_flags;
  logic [7:0] prev_y;
  logic [7:0] prev_cb;
  logic [7:0] prev_cr;
  logic [7:0] cr_hold;
  logic [7:0] cb_avg;
  logic [7:0] cr_avg;

  function automatic logic [7:0] avg(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + 9'd1;
    return s[8:1];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel <= '0;
      line  <= '0;
      halt  <= 1'b1;
    end else begin
      halt <= ~enable;
      if (enable) begin
        if (pixel == H_LAST) begin
          pixel <= '0;
          line  <= (line == V_LAST) ? 12'd0 : line + 12'd1;
        end else begin
          pixel <= pixel + 12'd1;
        end
      end
    end
  end

  always_comb begin
    line_end     = (pixel == H_LAST);
    frame_end    = line_end && (line == V_LAST);
    raw_flags[3] = (pixel < 12'(H_ACTIVE)) && (line < 12'(V_ACTIVE));
    raw_flags[2] = (pixel >= HS_FIRST) && (pixel <= HS_LAST);
    raw_flags[1] = (line >= VS_FIRST) && (line <= VS_LAST);
    raw_flags[0] = pixel[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) dly[i] <= '0;
    end else if (enable) begin
      dly[0] <= raw_flags;
      for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
    end
  end

  assign aligned = dly[LAT-1];
  assign cb_avg  = avg(prev_cb, Cb);
  assign cr_avg  = avg(prev_cr, Cr);

  // Even pixel leaves when its odd partner is at the inputs; the odd pixel's Cr average waits in cr_hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_flags <= '0;
      prev_y     <= '0;
      prev_cb    <= '0;
      prev_cr    <= '0;
      cr_hold    <= '0;
      vid_data   <= 16'h1080;
      vid_de     <= 1'b0;
      vid_hs     <= ~SYNC_ON;
      vid_vs     <= ~SYNC_ON;
    end else if (enable) begin
      prev_flags <= aligned;
      prev_y     <= Y;
      prev_cb    <= Cb;
      prev_cr    <= Cr;
      if (!prev_flags[0]) cr_hold <= cr_avg;
      vid_de   <= prev_flags[3];
      vid_hs   <= prev_flags[2] ? SYNC_ON : ~SYNC_ON;
      vid_vs   <= prev_flags[1] ? SYNC_ON : ~SYNC_ON;
      vid_data <= prev_flags[3] ? {prev_y, (prev_flags[0] ? cr_hold : cb_avg)} : 16'h1080;
    end
  end

endmodule

// File: tb/tb_video_timing_out.sv
// tb/tb_video_timing_out.sv - directed scoreboard bench for video_timing_out
module tb_video_timing_out;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6, VF = 1, VS = 2, VB = 1;
  localparam int LAT = 2;
  localparam int POL = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [11:0] pixel, line;
  logic        line_end, frame_end, halt;
  logic [7:0]  Y, Cb, Cr;
  logic [15:0] vid_data;
  logic        vid_de, vid_hs, vid_vs;

  video_timing_out #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .LAT(LAT), .SYNC_POL(POL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .pixel(pixel), .line(line), .line_end(line_end), .frame_end(frame_end), .halt(halt),
    .Y(Y), .Cb(Cb), .Cr(Cr),
    .vid_data(vid_data), .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [18:0] sb[$];
  logic [18:0] cur;
  logic        exp_halt;
  int mp, ml;
  int sp [LAT];
  int sl [LAT];

  localparam logic IDLE = (POL == 0);

  function automatic logic act(int p, int l);
    return (p < HA) && (l < VA);
  endfunction
  function automatic logic [7:0] y_of(int p, int l);
    return act(p, l) ? 8'(p + l * 3) : 8'hFF;
  endfunction
  function automatic logic [7:0] cb_of(int p, int l);
    return act(p, l) ? 8'(8'h40 + (p % 2) + l * 37) : 8'hFF;
  endfunction
  function automatic logic [7:0] cr_of(int p, int l);
    return act(p, l) ? 8'(8'hC0 + 3 * (p % 2) + l * 11) : 8'hFF;
  endfunction
  function automatic logic [7:0] mean(logic [7:0] a, logic [7:0] b);
    int s;
    s = (int'(a) + int'(b) + 1) / 2;
    return 8'(s);
  endfunction

  function automatic logic [18:0] exp_of(int p, int l);
    logic de, hs, vs;
    logic [15:0] d;
    de = act(p, l);
    hs = (p >= HA + HF) && (p < HA + HF + HS);
    vs = (l >= VA + VF) && (l < VA + VF + VS);
    if (!de) d = 16'h1080;
    else if (p % 2 == 0) d = {y_of(p, l), mean(cb_of(p, l), cb_of(p + 1, l))};
    else d = {y_of(p, l), mean(cr_of(p - 1, l), cr_of(p, l))};
    return {de, (hs ? ~IDLE : IDLE), (vs ? ~IDLE : IDLE), d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (pixel model %0d line model %0d)", tag, obs, exp, mp, ml);
    end
  endtask

  task automatic drive_inputs();
    Y  = y_of(sp[LAT-1], sl[LAT-1]);
    Cb = cb_of(sp[LAT-1], sl[LAT-1]);
    Cr = cr_of(sp[LAT-1], sl[LAT-1]);
  endtask

  task automatic reset_model();
    mp = 0;
    ml = 0;
    for (int i = 0; i < LAT; i++) begin
      sp[i] = HT - 1;
      sl[i] = VT - 1;
    end
    cur = {1'b0, IDLE, IDLE, 16'h1080};
    sb.delete();
    repeat (LAT + 1) sb.push_back(cur);
    exp_halt = 1'b1;
  endtask

  task automatic check_all();
    chk("pixel", 32'(pixel), 32'(mp));
    chk("line", 32'(line), 32'(ml));
    chk("line_end", 32'(line_end), 32'(mp == HT - 1));
    chk("frame_end", 32'(frame_end), 32'((mp == HT - 1) && (ml == VT - 1)));
    chk("halt", 32'(halt), 32'(exp_halt));
    chk("vid_de", 32'(vid_de), 32'(cur[18]));
    chk("vid_hs", 32'(vid_hs), 32'(cur[17]));
    chk("vid_vs", 32'(vid_vs), 32'(cur[16]));
    chk("vid_data", 32'(vid_data), 32'(cur[15:0]));
  endtask

  task automatic step(input logic en);
    enable = en;
    if (en) sb.push_back(exp_of(mp, ml));
    @(posedge clk);
    #1;
    if (en) begin
      for (int i = LAT - 1; i > 0; i--) begin
        sp[i] = sp[i-1];
        sl[i] = sl[i-1];
      end
      sp[0] = mp;
      sl[0] = ml;
      if (mp == HT - 1) begin
        mp = 0;
        ml = (ml == VT - 1) ? 0 : ml + 1;
      end else begin
        mp++;
      end
      if (sb.size() == 0) chk("scoreboard_empty", 32'd0, 32'd1);
      else cur = sb.pop_front();
    end
    exp_halt = ~en;
    check_all();
    drive_inputs();
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    reset_model();
    drive_inputs();
    repeat (3) @(posedge clk);
    #1;
    check_all();

    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * HT * VT + 40) step(1'b1);

    for (int k = 0; k < HT && mp != 10; k++) step(1'b1);
    chk("freeze_start_pixel", 32'(mp), 32'd10);
    repeat (10) step(1'b0);
    repeat (HT) step(1'b1);

    for (int k = 0; k < HT * VT && !(ml == 3 && mp == 5); k++) step(1'b1);
    chk("mid_reset_line", 32'(ml), 32'd3);
    #3;
    rst_n = 1'b0;
    #1;
    reset_model();
    check_all();
    drive_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (HT * 3) step(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
